// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) doubling, state column addressing and the
// handshake FSM state encoding used by the MixColumns engine.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mc_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // Column 0 occupies the most significant 32 bits of the 128-bit state.
    function automatic int col_msb(input logic [1:0] col);
        return 127 - 32 * int'(col);
    endfunction

endpackage

// File: rtl/mixcol_column.sv
// One AES column through MixColumns; with INV_EN the optional pre-stage turns
// the same forward network into InvMixColumns.
module mixcol_column
    import aes_pkg::*;
#(
    parameter bit INV_EN = 1'b1
) (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] c,
    input  logic [7:0] d,
    input  logic       inv,
    output logic [7:0] a_o,
    output logic [7:0] b_o,
    output logic [7:0] c_o,
    output logic [7:0] d_o
);

    logic [7:0] pa, pb, pc, pd;
    logic [7:0] t;

    generate
        if (INV_EN) begin : g_inv
            logic [7:0] u, v;
            // InvMixColumns factors as MixColumns applied after adding 4*(a^c) / 4*(b^d).
            assign u  = inv ? xtime(xtime(a ^ c)) : 8'h00;
            assign v  = inv ? xtime(xtime(b ^ d)) : 8'h00;
            assign pa = a ^ u;
            assign pb = b ^ v;
            assign pc = c ^ u;
            assign pd = d ^ v;
        end else begin : g_fwd
            logic unused_inv;
            assign unused_inv = inv;
            assign pa = a;
            assign pb = b;
            assign pc = c;
            assign pd = d;
        end
    endgenerate

    assign t   = pa ^ pb ^ pc ^ pd;
    assign a_o = pa ^ t ^ xtime(pa ^ pb);
    assign b_o = pb ^ t ^ xtime(pb ^ pc);
    assign c_o = pc ^ t ^ xtime(pc ^ pd);
    assign d_o = pd ^ t ^ xtime(pd ^ pa);

endmodule

// File: rtl/mixcol_engine.sv
// Iterative valid/ready MixColumns / InvMixColumns engine over a 128-bit AES
// state, transforming COLS_PER_CYC columns in place per clock.
module mixcol_engine
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYC = 1,
    parameter bit INV_EN       = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [127:0] state_in,
    input  logic         inv,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [127:0] state_out
);

    localparam logic [1:0] STEP = 2'(COLS_PER_CYC);
    localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYC);

    mc_state_e    state_q, state_d;
    logic [1:0]   col_idx_q, col_idx_d;
    logic [127:0] data_q, data_d;
    logic         inv_q, inv_d;

    logic [COLS_PER_CYC-1:0][31:0] col_in;
    logic [COLS_PER_CYC-1:0][31:0] col_out;

    always_comb begin
        col_in = '0;
        for (int g = 0; g < COLS_PER_CYC; g++) begin
            col_in[g] = data_q[col_msb(col_idx_q + 2'(g)) -: 32];
        end
    end

    generate
        for (genvar g = 0; g < COLS_PER_CYC; g++) begin : g_col
            mixcol_column #(
                .INV_EN(INV_EN)
            ) u_col (
                .a  (col_in[g][31:24]),
                .b  (col_in[g][23:16]),
                .c  (col_in[g][15:8]),
                .d  (col_in[g][7:0]),
                .inv(inv_q),
                .a_o(col_out[g][31:24]),
                .b_o(col_out[g][23:16]),
                .c_o(col_out[g][15:8]),
                .d_o(col_out[g][7:0])
            );
        end
    endgenerate

    // The working register doubles as the result register, so state_out is
    // frozen for free once the FSM parks in DONE.
    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        data_d    = data_q;
        inv_d     = inv_q;
        case (state_q)
            IDLE: begin
                if (in_vld) begin
                    data_d    = state_in;
                    inv_d     = inv & INV_EN;
                    col_idx_d = 2'd0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                for (int g = 0; g < COLS_PER_CYC; g++) begin
                    data_d[col_msb(col_idx_q + 2'(g)) -: 32] = col_out[g];
                end
                col_idx_d = col_idx_q + STEP;
                if (col_idx_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            col_idx_q <= 2'd0;
            data_q    <= '0;
            inv_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            data_q    <= data_d;
            inv_q     <= inv_d;
        end
    end

    assign in_rdy    = (state_q == IDLE) && rst;
    assign out_vld   = (state_q == DONE);
    assign state_out = data_q;

endmodule

// File: tb/tb_mixcol_engine.sv
// Directed checks of mixcol_engine built three ways (1 col/cycle, 2 col/cycle,
// 4 col/cycle forward-only), all sharing one stimulus stream.
module tb_mixcol_engine;

    localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] FIPS_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] COLS_IN  = 128'hdb135345_f20a225c_c6c6c6c6_2d26314c;
    localparam logic [127:0] COLS_OUT = 128'h8e4da1bc_9fdc589d_c6c6c6c6_4d7ebdf8;

    logic         clk;
    logic         rst;
    logic         in_vld;
    logic [127:0] state_in;
    logic         inv;
    logic         out_rdy;
    logic [2:0]   in_rdy_w;
    logic [2:0]   out_vld_w;
    logic [127:0] state_out_w [3];

    int checks;
    int errors;

    mixcol_engine #(.COLS_PER_CYC(1), .INV_EN(1'b1)) dut_c1 (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy_w[0]),
        .state_in(state_in), .inv(inv), .out_vld(out_vld_w[0]),
        .out_rdy(out_rdy), .state_out(state_out_w[0])
    );

    mixcol_engine #(.COLS_PER_CYC(2), .INV_EN(1'b1)) dut_c2 (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy_w[1]),
        .state_in(state_in), .inv(inv), .out_vld(out_vld_w[1]),
        .out_rdy(out_rdy), .state_out(state_out_w[1])
    );

    mixcol_engine #(.COLS_PER_CYC(4), .INV_EN(1'b0)) dut_c4 (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy_w[2]),
        .state_in(state_in), .inv(inv), .out_vld(out_vld_w[2]),
        .out_rdy(out_rdy), .state_out(state_out_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int run_cycles(input int i);
        case (i)
            0:       return 4;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic bit has_inv(input int i);
        return i != 2;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = x;
        for (int k = 0; k < 8; k++) begin
            if (y[k]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1B) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    // Textbook circulant-matrix model, independent of the RTL's pre-stage trick.
    function automatic logic [31:0] model_col(input logic [31:0] col, input logic inv_bit);
        logic [7:0] s [4];
        logic [7:0] coef [4];
        logic [7:0] r;
        logic [31:0] res;
        s[0] = col[31:24]; s[1] = col[23:16]; s[2] = col[15:8]; s[3] = col[7:0];
        if (inv_bit) begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        res = '0;
        for (int row = 0; row < 4; row++) begin
            r = 8'h00;
            for (int j = 0; j < 4; j++) r = r ^ gmul(s[j], coef[(j - row) & 3]);
            res[31 - 8*row -: 8] = r;
        end
        return res;
    endfunction

    function automatic logic [127:0] model_state(input logic [127:0] s, input logic inv_bit);
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < 4; c++) res[127 - 32*c -: 32] = model_col(s[127 - 32*c -: 32], inv_bit);
        return res;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one block with out_rdy high; check latency and data on every build.
    task automatic run_block(input logic [127:0] din, input logic inv_bit,
                             input logic [127:0] exp_inv_build,
                             input logic [127:0] exp_fwd_build, input string name);
        int           first [3];
        logic [127:0] got [3];
        logic [127:0] exp;
        in_vld   = 1'b1;
        state_in = din;
        inv      = inv_bit;
        out_rdy  = 1'b1;
        checks++;
        if (in_rdy_w !== 3'b111) begin
            errors++;
            $display("[TB] FAIL %s in_rdy before accept: got %b want 111", name, in_rdy_w);
        end
        for (int i = 0; i < 3; i++) begin
            first[i] = 0;
            got[i]   = '0;
        end
        for (int j = 1; j <= 10; j++) begin
            step();
            in_vld   = 1'b0;
            inv      = 1'b0;
            state_in = '0;
            for (int i = 0; i < 3; i++) begin
                if (out_vld_w[i] === 1'b1 && first[i] == 0) begin
                    first[i] = j;
                    got[i]   = state_out_w[i];
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            exp = has_inv(i) ? exp_inv_build : exp_fwd_build;
            checks++;
            if (first[i] != run_cycles(i) + 1) begin
                errors++;
                $display("[TB] FAIL %s latency dut%0d: got %0d want %0d", name, i, first[i], run_cycles(i) + 1);
            end
            checks++;
            if (got[i] !== exp) begin
                errors++;
                $display("[TB] FAIL %s data dut%0d: got %h want %h", name, i, got[i], exp);
            end
        end
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        in_vld   = 1'b0;
        state_in = '0;
        inv      = 1'b0;
        out_rdy  = 1'b0;
        repeat (3) step();
        checks++;
        if (out_vld_w !== 3'b000 || in_rdy_w !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset flags: got vld=%b rdy=%b want 000/000", out_vld_w, in_rdy_w);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (state_out_w[i] !== 128'h0) begin
                errors++;
                $display("[TB] FAIL reset state_out dut%0d: got %h want 0", i, state_out_w[i]);
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_rdy_w !== 3'b111) begin
            errors++;
            $display("[TB] FAIL reset release in_rdy: got %b want 111", in_rdy_w);
        end
        step();
    endtask

    task automatic test_vectors();
        run_block(FIPS_IN, 1'b0, FIPS_OUT, FIPS_OUT, "fips_fwd");
        run_block(FIPS_OUT, 1'b1, FIPS_IN, model_state(FIPS_OUT, 1'b0), "fips_inv");
        run_block(FIPS_IN, 1'b1, model_state(FIPS_IN, 1'b1), FIPS_OUT, "inv_disabled");
        run_block(COLS_IN, 1'b0, COLS_OUT, COLS_OUT, "col_ident");
        run_block(COLS_OUT, 1'b1, COLS_IN, model_state(COLS_OUT, 1'b0), "col_ident_inv");
    endtask

    task automatic test_random();
        logic [127:0] din;
        logic         b;
        for (int n = 0; n < 40; n++) begin
            din = {$urandom, $urandom, $urandom, $urandom};
            b   = 1'($urandom_range(0, 1));
            run_block(din, b, model_state(din, b), model_state(din, 1'b0), "rand");
            run_block(model_state(din, 1'b0), 1'b1, din,
                      model_state(model_state(din, 1'b0), 1'b0), "roundtrip");
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] snap [3];
        in_vld   = 1'b1;
        state_in = FIPS_IN;
        inv      = 1'b0;
        out_rdy  = 1'b0;
        step();
        state_in = COLS_IN;
        for (int j = 0; j < 8 && out_vld_w !== 3'b111; j++) step();
        checks++;
        if (out_vld_w !== 3'b111) begin
            errors++;
            $display("[TB] FAIL bp out_vld timeout: got %b want 111", out_vld_w);
        end
        for (int i = 0; i < 3; i++) begin
            snap[i] = state_out_w[i];
            checks++;
            if (snap[i] !== FIPS_OUT) begin
                errors++;
                $display("[TB] FAIL bp data dut%0d: got %h want %h", i, snap[i], FIPS_OUT);
            end
        end
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (out_vld_w !== 3'b111 || in_rdy_w !== 3'b000) begin
                errors++;
                $display("[TB] FAIL bp hold flags cyc%0d: got vld=%b rdy=%b want 111/000", k, out_vld_w, in_rdy_w);
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (state_out_w[i] !== snap[i]) begin
                    errors++;
                    $display("[TB] FAIL bp stable dut%0d cyc%0d: got %h want %h", i, k, state_out_w[i], snap[i]);
                end
            end
        end
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        step();
        checks++;
        if (out_vld_w !== 3'b000 || in_rdy_w !== 3'b111) begin
            errors++;
            $display("[TB] FAIL bp release: got vld=%b rdy=%b want 000/111", out_vld_w, in_rdy_w);
        end
    endtask

    task automatic test_back_to_back();
        int hits [3][2];
        int nh [3];
        for (int i = 0; i < 3; i++) begin
            nh[i] = 0;
            hits[i][0] = 0;
            hits[i][1] = 0;
        end
        in_vld   = 1'b1;
        state_in = FIPS_IN;
        inv      = 1'b0;
        out_rdy  = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                if (out_vld_w[i] === 1'b1 && nh[i] < 2) begin
                    hits[i][nh[i]] = j;
                    nh[i]++;
                end
            end
        end
        in_vld = 1'b0;
        repeat (8) step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (nh[i] != 2 || hits[i][1] - hits[i][0] != run_cycles(i) + 2) begin
                errors++;
                $display("[TB] FAIL b2b period dut%0d: got %0d (hits %0d) want %0d", i,
                         hits[i][1] - hits[i][0], nh[i], run_cycles(i) + 2);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        in_vld   = 1'b1;
        state_in = FIPS_IN;
        inv      = 1'b0;
        out_rdy  = 1'b0;
        step();
        in_vld = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        checks++;
        if (out_vld_w !== 3'b000 || in_rdy_w !== 3'b000) begin
            errors++;
            $display("[TB] FAIL midrun reset flags: got vld=%b rdy=%b want 000/000", out_vld_w, in_rdy_w);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (state_out_w[i] !== 128'h0) begin
                errors++;
                $display("[TB] FAIL midrun state_out dut%0d: got %h want 0", i, state_out_w[i]);
            end
        end
        rst     = 1'b1;
        out_rdy = 1'b1;
        #1;
        checks++;
        if (in_rdy_w !== 3'b111) begin
            errors++;
            $display("[TB] FAIL midrun in_rdy: got %b want 111", in_rdy_w);
        end
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (out_vld_w !== 3'b000) begin
                errors++;
                $display("[TB] FAIL midrun spurious out_vld cyc%0d: got %b want 000", k, out_vld_w);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_vectors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        run_block(FIPS_IN, 1'b0, FIPS_OUT, FIPS_OUT, "after_all");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
